// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : booth_seq_mult_if                                         |
// | Purpose  : start/busy/done handshake and operand/product bundle      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface booth_seq_mult_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : booth_seq_mult (with csa)                                 |
// | Purpose  : radix-2 Booth sequential multiplier, 32 iterations on one |
// |            shared carry-select adder. Option: BOOTH_ZERO_SKIP_EN     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module csa (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout,
   output logic        overflow
);
   logic [16:0] lo;
   logic [16:0] hi0;
   logic [16:0] hi1;

   assign lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
   assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
   assign hi1 = hi0 + 17'd1;

   assign {cout, sum[31:16]} = lo[16] ? hi1 : hi0;
   assign sum[15:0]          = lo[15:0];
   // carry into the MSB differs from carry out exactly on signed overflow
   assign overflow = (sum[31] ^ a[31] ^ b[31]) ^ cout;
endmodule

module booth_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   booth_seq_mult_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic                 qm1_q, qm1_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic                 add_en;
   logic [WIDTH-1:0]     add_b;
   logic                 add_cin;
   logic [WIDTH-1:0]     add_sum;
   logic                 add_ovf;
   logic                 add_cout_unused;
   logic [WIDTH-1:0]     sel_r;
   logic                 sign_s;

   csa u_csa (
      .a        (a_q),
      .b        (add_b),
      .cin      (add_cin),
      .sum      (add_sum),
      .cout     (add_cout_unused),
      .overflow (add_ovf)
   );

   always_comb begin
      add_en  = 1'b0;
      add_b   = m_q;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         case ({q_q[0], qm1_q})
            2'b01: add_en = 1'b1;
            2'b10: begin
               add_en  = 1'b1;
               add_b   = ~m_q;
               add_cin = 1'b1;
            end
            default: add_en = 1'b0;
         endcase
      end
   end

   // sum[MSB] alone is wrong when the add/sub overflows (e.g. M = -2^31)
   assign sel_r  = add_en ? add_sum : a_q;
   assign sign_s = add_en ? (add_sum[WIDTH-1] ^ add_ovf) : a_q[WIDTH-1];

`ifdef BOOTH_ZERO_SKIP_EN
   logic start_zero;
   assign start_zero = (bus.multiplicand == '0) || (bus.multiplier == '0);
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               a_d   = '0;
               q_d   = bus.multiplier;
               qm1_d = 1'b0;
               m_d   = bus.multiplicand;
               cnt_d = '0;
`ifdef BOOTH_ZERO_SKIP_EN
               if (start_zero) begin
                  state_d   = S_DONE;
                  product_d = '0;
               end else begin
                  state_d = S_RUN;
               end
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            a_d   = {sign_s, sel_r[WIDTH-1:1]};
            q_d   = {sel_r[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d   = S_DONE;
               product_d = {sign_s, sel_r, q_q[WIDTH-1:1]};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         m_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = (state_q == S_RUN);
   assign bus.done    = (state_q == S_DONE);
   assign bus.product = product_q;
endmodule
`default_nettype wire

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
- Sequential radix-2 Booth multiplier controller for the Booth multiplier path.
- Sequences one shared 32-bit carry-select adder (`CSA`: a, b, cin -> sum, cout, overflow) through 32 add/subtract-and-shift iterations.
- Produces a signed 64-bit product; start/busy/done handshake toward the issuing unit.

Parameters:
- WIDTH, 32, operand width; fixed at 32 to match the `CSA` instance; iteration count = WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- multiplicand  input  32  signed M; captured when start is accepted
- multiplier  input  32  signed Q; captured when start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when product is valid
- product  output  64  signed result {A,Q}; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0; product=0.
  - A, Q, q_m1, M and the iteration counter cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: load A=0, Q=multiplier, q_m1=0, M=multiplicand, cnt=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN: one Booth iteration per cycle, using the `CSA` instance combinationally:
  - {Q[0],q_m1}=01: adder a=A, b=M, cin=0.
  - {Q[0],q_m1}=10: adder a=A, b=~M, cin=1 (subtract).
  - 00 or 11: A passes unchanged; adder result is unused.
  - True sign s = sum[31] XOR overflow for add/sub cycles, A[31] otherwise. This handles M=0x8000_0000 correctly.
  - Shift: {A,Q,q_m1} <= {s, R[31:0], Q[31:0]} >> 1, where R is the selected value. Equivalently A<={s,R[31:1]}, Q<={R[0],Q[31:1]}, q_m1<=Q[0].
  - cnt increments; after the iteration with cnt=31, go to DONE.
  - The adder's cout is unused.
- DONE:
  - done=1 for exactly one cycle; product={A,Q} is registered on entry to DONE.
  - start=1 in DONE is accepted: loads new operands and goes to RUN. This gives back-to-back operation.
  - Otherwise go to IDLE.
- start while in RUN is ignored; operands are not recaptured.
- Latency:
  - start sampled at edge t; RUN occupies edges t+1..t+32.
  - done=1 during the cycle after edge t+32.
  - Issue interval is 33 cycles.
- product changes only on entry to DONE and stays stable otherwise, including through IDLE.
- busy=1 iff state=RUN; done and busy are never both high.

Optional Feature:
- Macro BOOTH_ZERO_SKIP_EN.
- Defined: on an accepted start with multiplicand==0 or multiplier==0:
  - Go directly to DONE next cycle with product=0; busy stays 0.
  - Latency is 1 cycle.
- Undefined: zero operands run the full 32 iterations and produce product=0 with normal latency.

Test Plan:
- 3 x 5: start for 1 cycle -> busy for 32 cycles, done 33 cycles after start, product=0x0000_0000_0000_000F.
- -7 x 6 (0xFFFF_FFF9, 0x0000_0006) -> product=0xFFFF_FFFF_FFFF_FFD6.
- 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000; 0x8000_0000 x 0xFFFF_FFFF -> 0x0000_0000_8000_0000. Both check overflow-corrected sign.
- start pulsed with new operands at RUN cycle 10 -> ignored, original product delivered. Then start held in the DONE cycle with 2 x 2 -> immediate RUN, next product=4.
- rst_n pulled low at RUN cycle 15 -> outputs zero immediately with no clock edge, no done. Next start 9 x 9 -> 81 at normal latency.
- 0 x 0x1234_5678: with BOOTH_ZERO_SKIP_EN, done 1 cycle after start and product=0. Without the macro, done after 33 cycles and product=0.
